mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Bus initiator for the team's asynchronous-strobe memory (address bus, active-high `read` and `write` strobes, shared tristate data bus; the memory stores on the rising edge of `write` while `read` is low and drives data while `read` is high and `write` is low). Converts a synchronous valid/ready request into a correctly sequenced strobe cycle and returns read data with a one-cycle response pulse. Sits between a sequencer/CPU datapath and one memory instance, one transaction at a time.

## Interface
- `DWIDTH`, 8, data bus width in bits
- `AWIDTH`, 5, address width in bits
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request this cycle
- `req_write`  in  1  1 = write, 0 = read (sampled on accept)
- `req_addr`  in  AWIDTH  target address (sampled on accept)
- `req_wdata`  in  DWIDTH  write data (sampled on accept)
- `rsp_valid`  out  1  one-cycle pulse: transaction finished
- `rsp_rdata`  out  DWIDTH  captured read data, valid with `rsp_valid` after a read
- `addr`  out  AWIDTH  memory address bus
- `read`  out  1  memory read strobe
- `write`  out  1  memory write strobe
- `data`  inout  DWIDTH  shared memory data bus

## Operation
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_SAMPLE, DONE.
- Accept = `req_valid && req_ready`; `req_ready` = 1 only in IDLE. On accept, latch write flag, address, write data.
- IDLE -> W_SETUP (write) or R_SETUP (read) on accept; otherwise stay.
- W_SETUP: `addr` driven, `data` driven with latched wdata, `write`=0, `read`=0. -> W_PULSE.
- W_PULSE: `write`=1, addr/data held. -> W_HOLD.
- W_HOLD: `write`=0, addr/data still held (hold time). -> DONE.
- R_SETUP: `addr` driven, `read`=1, `data` released (Z). -> R_SAMPLE.
- R_SAMPLE: `read`=1; at end of cycle `rsp_rdata` <= `data`. -> DONE.
- DONE: `read`=0, `write`=0, `data` Z, `rsp_valid`=1. -> IDLE.
- `read` and `write` never both 1. `data` driven only in W_SETUP/W_PULSE/W_HOLD; never driven while `read`=1.
- `rsp_rdata` holds its last captured value; unchanged by writes.
- Strobes, `addr`, `req_ready`, `rsp_valid` are registered outputs (no combinational path from request inputs).
- Request inputs ignored outside IDLE; changes after accept have no effect.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `addr`=0, `read`=0, `write`=0, `data`=Z.
- Cycle 0 = accept edge. Write: W_SETUP c1, `write` high c2, W_HOLD c3, `rsp_valid` c4, `req_ready` high c5. 5 cycles accept-to-accept.
- Read: `read` high c1–c2, data sampled at end of c2, `rsp_valid`/`rsp_rdata` c3, `req_ready` c4. 4 cycles accept-to-accept.
- Memory write occurs on the `write` rising edge at c2, with addr/data stable since c1 and through c3.
- Back-to-back: IDLE (and DONE) between transactions guarantees ≥1 cycle with both strobes low and bus Z (turnaround) between any read and a following write.
- Reset asserted mid-transaction: outputs go to reset values immediately (asynchronous), bus released, transaction abandoned, no `rsp_valid`; a pending write is not retried.
- Reset released: first accept possible on first rising edge after deassertion.

## Test plan
- Write 0xA5 to addr 3 -> `write` high exactly one cycle (c2), `data`=0xA5 and `addr`=3 stable c1–c3, `rsp_valid` at c4; subsequent read of addr 3 returns `rsp_rdata`=0xA5 at c3.
- Write 0x00/0xFF to addr 0 and 31 (address extremes), read back -> 0x00 and 0xFF, no aliasing.
- Back-to-back write(5,0x3C), read(5), write(6,0xC3) with `req_valid` held high -> accepts only in IDLE, read returns 0x3C, `read` and `write` never overlap, `data` never driven while `read`=1.
- `req_valid` high with `req_addr` changing during a busy transaction -> changes ignored; exactly one accept per IDLE.
- Assert `rst` during W_PULSE -> `write`, `read` drop to 0 and `data` Z in the same cycle, `req_ready`=1, no `rsp_valid`; `rsp_rdata`=0.
- Read after reset from an address written before reset -> controller completes normally, `rsp_valid` at c3 with memory contents.

Source files
------------

// File: rtl/mem_bus_master.sv
// Bus initiator for the asynchronous-strobe memory: turns a valid/ready request
// into a setup/strobe/hold sequence and returns read data with a one-cycle pulse.
module mem_bus_master #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [AWIDTH-1:0] addr,
    output logic              read,
    output logic              write,
    inout  wire  [DWIDTH-1:0] data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_PULSE  = 3'd2,
        W_HOLD   = 3'd3,
        R_SETUP  = 3'd4,
        R_SAMPLE = 3'd5,
        DONE     = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                drive_q, drive_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                accept;

    // req_ready_q is high exactly when the FSM sits in IDLE
    assign accept = req_valid && req_ready_q;

    // State register plus all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            drive_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            read_q      <= read_d;
            write_q     <= write_d;
            drive_q     <= drive_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = req_write ? W_SETUP : R_SETUP;
            W_SETUP:  state_d = W_PULSE;
            W_PULSE:  state_d = W_HOLD;
            W_HOLD:   state_d = DONE;
            R_SETUP:  state_d = R_SAMPLE;
            R_SAMPLE: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        write_d     = (state_d == W_PULSE);
        read_d      = (state_d == R_SETUP) || (state_d == R_SAMPLE);
        drive_d     = (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        if (state_q == R_SAMPLE) begin
            rsp_rdata_d = data;
        end
    end

    assign data      = drive_q ? wdata_q : {DWIDTH{1'bz}};
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr      = addr_q;
    assign read      = read_q;
    assign write     = write_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with a behavioural strobe memory on the bus
// and an array-based reference model of what every read should return.
module tb_mem_bus_master;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] addr;
    logic          read;
    logic          write;
    wire  [DW-1:0] data;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rd;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_bus_master #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .addr      (addr),
        .read      (read),
        .write     (write),
        .data      (data)
    );

    // Asynchronous memory: drives while read && !write, stores on write rising edge
    assign data = (read && !write) ? mem[addr] : {DW{1'bz}};

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i * 37 + 11);
        forever begin
            @(posedge write);
            mem[addr] = data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Starts and ends at a negedge in IDLE; req_valid is left high afterwards.
    task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_rd);
        int len;
        len = we ? 4 : 3;
        chk("ready_idle", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_write = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_write = 1'($urandom);
                req_addr  = AW'($urandom);
                req_wdata = DW'($urandom);
            end
            chk("write_strobe", 32'(write), 32'(we && c == 2));
            chk("read_strobe", 32'(read), 32'(!we && c <= 2));
            chk("strobe_overlap", 32'(read && write), 32'(0));
            chk("rsp_valid", 32'(rsp_valid), 32'(c == len));
            chk("ready_busy", 32'(req_ready), 32'(0));
            if (we && c <= 3) begin
                chk("w_addr", 32'(addr), 32'(a));
                chk("w_data", 32'(data), 32'(d));
            end
            if (!we && c <= 2) chk("r_addr", 32'(addr), 32'(a));
            if (c == len) chk(we ? "rdata_kept" : "rdata", 32'(rsp_rdata), 32'(exp_rd));
        end
        @(negedge clk);
        chk("ready_after", 32'(req_ready), 32'(1));
        chk("strobes_after", 32'({read, write}), 32'(0));
        if (we) ref_mem[a] = d;
        else last_rd = exp_rd;
    endtask

    initial begin
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = DW'(i * 37 + 11);
        last_rd = '0;

        vecs[0] = '{1'b1, 5'd3,  8'hA5, 8'h00};
        vecs[1] = '{1'b0, 5'd3,  8'h00, 8'hA5};
        vecs[2] = '{1'b1, 5'd0,  8'h00, 8'h00};
        vecs[3] = '{1'b1, 5'd31, 8'hFF, 8'h00};
        vecs[4] = '{1'b0, 5'd0,  8'h00, 8'h00};
        vecs[5] = '{1'b0, 5'd31, 8'h00, 8'hFF};
        vecs[6] = '{1'b1, 5'd5,  8'h3C, 8'h00};
        vecs[7] = '{1'b0, 5'd5,  8'h00, 8'h3C};
        vecs[8] = '{1'b1, 5'd6,  8'hC3, 8'h00};
        vecs[9] = '{1'b0, 5'd6,  8'h00, 8'hC3};

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_addr", 32'(addr), 32'(0));
        chk("rst_strobes", 32'({read, write}), 32'(0));
        rst = 1'b0;

        // Directed table, applied back-to-back with req_valid held high
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].we ? last_rd : vecs[i].exp);
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Random traffic against the reference array, with occasional idle gaps
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            a  = AW'($urandom_range(0, 31));
            d  = DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("gap_no_rsp", 32'(rsp_valid), 32'(0));
                end
            end
            run_txn(we, a, d, we ? last_rd : ref_mem[a]);
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Reset during W_PULSE: the write edge already occurred, the response is lost
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd9;
        req_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pulse_before_rst", 32'(write), 32'(1));
        rst = 1'b1;
        #1;
        chk("arst_write", 32'(write), 32'(0));
        chk("arst_read", 32'(read), 32'(0));
        chk("arst_ready", 32'(req_ready), 32'(1));
        chk("arst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("arst_rdata", 32'(rsp_rdata), 32'(0));
        chk("arst_addr", 32'(addr), 32'(0));
        ref_mem[9] = 8'h77;
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({rsp_valid, read, write}), 32'(0));
        end

        // Reads after reset return contents written before it
        run_txn(1'b0, 5'd9, 8'h00, ref_mem[9]);
        run_txn(1'b0, 5'd31, 8'h00, ref_mem[31]);
        run_txn(1'b0, 5'd3, 8'h00, ref_mem[3]);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
